mul_hilo_ctrl: RTL and testbench

MUL_HILO_CTRL -- requirements
Module: mul_hilo_ctrl

---
 rtl/mul_hilo_ctrl.sv | 122 ++++++++++++
 tb/tb_mul_hilo_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl.sv
// Sequencer for an external 32x32 combinational multiplier with HI/LO result registers.
// Optional MUL_SIGNED_EN adds signed operand handling (magnitudes out, product negated on capture).
module mul_hilo_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        is_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic [31:0] op_a_eff, op_b_eff;
  logic [63:0] prod;

`ifdef MUL_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes go to the unsigned multiplier; 0x80000000 negates to itself, which is the right magnitude.
  always_comb begin
    op_a_eff = (is_signed && op_a[31]) ? 32'(32'd0 - op_a) : op_a;
    op_b_eff = (is_signed && op_b[31]) ? 32'(32'd0 - op_b) : op_b;
    sign_d   = sign_q;
    if (state_q == IDLE && start) sign_d = is_signed & (op_a[31] ^ op_b[31]);
    prod     = sign_q ? 64'(~mul_result + 64'd1) : mul_result;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) sign_q <= 1'b0;
    else          sign_q <= sign_d;
  end
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign op_a_eff = op_a;
  assign op_b_eff = op_b;
  assign prod     = mul_result;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over direct HI/LO writes in the same cycle
        if (start) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
          mul_a_d = op_a_eff;
          mul_b_d = op_b_eff;
        end else begin
          if (hi_wr) hi_d = wr_data;
          if (lo_wr) lo_d = wr_data;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      CAPTURE: begin
        state_d = IDLE;
        hi_d    = prod[63:32];
        lo_d    = prod[31:0];
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mul_a_q <= 32'd0;
      mul_b_q <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign done  = done_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Randomized self-checking bench for mul_hilo_ctrl against an arithmetic reference model.
module tb_mul_hilo_ctrl;
  localparam int S = 2;

  logic        clock = 1'b0;
  logic        clear_n, start, is_signed, hi_wr, lo_wr, busy, done;
  logic [31:0] op_a, op_b, mul_a, mul_b, wr_data, hi, lo;
  logic [63:0] mul_result;
  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  // Stand-in for the downstream combinational multiplier.
  assign mul_result = {32'd0, mul_a} * {32'd0, mul_b};

  mul_hilo_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .op_a(op_a), .op_b(op_b),
    .is_signed(is_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb;
`ifdef MUL_SIGNED_EN
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
`endif
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] ref_operand(input logic [31:0] a, input bit s);
`ifdef MUL_SIGNED_EN
    if (s && a[31]) return 32'(64'd4294967296 - {32'd0, a});
`endif
    return a;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue one multiply and check operands, exact done timing, and the result.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit s,
                        input bit with_hw, input string tag);
    logic [63:0] p;
    logic [31:0] ea, eb;
    p  = ref_prod(a, b, s);
    ea = ref_operand(a, s);
    eb = ref_operand(b, s);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    hi_wr = with_hw; wr_data = 32'h0BAD_0BAD;
    tick;
    start = 1'b0; hi_wr = 1'b0;
    checks++;
    if (busy !== 1'b1 || mul_a !== ea || mul_b !== eb) begin
      failures++;
      $display("FAIL %s accept: busy=%b mul_a=%h mul_b=%h want busy=1 mul_a=%h mul_b=%h",
               tag, busy, mul_a, mul_b, ea, eb);
    end
    for (int k = 1; k <= S + 1; k++) begin
      op_a = $urandom; op_b = $urandom;
      tick;
      checks++;
      if (done !== (k == S + 1) || mul_a !== ea || mul_b !== eb) begin
        failures++;
        $display("FAIL %s step%0d: done=%b mul_a=%h mul_b=%h want done=%b mul_a=%h mul_b=%h",
                 tag, k, done, mul_a, mul_b, (k == S + 1), ea, eb);
      end
    end
    checks++;
    if (hi !== p[63:32] || lo !== p[31:0] || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result: hi=%h lo=%h busy=%b want hi=%h lo=%h busy=0",
               tag, hi, lo, busy, p[63:32], p[31:0]);
    end
    tick;
    checks++;
    if (done !== 1'b0 || mul_a !== ea || mul_b !== eb || hi !== p[63:32] || lo !== p[31:0]) begin
      failures++;
      $display("FAIL %s idle_hold: done=%b mul_a=%h hi=%h lo=%h want done=0 mul_a=%h hi=%h lo=%h",
               tag, done, mul_a, hi, lo, ea, p[63:32], p[31:0]);
    end
  endtask

  task automatic test_reset;
    clear_n = 1'b0; start = 1'b0; op_a = 32'd0; op_b = 32'd0; is_signed = 1'b0;
    hi_wr = 1'b0; lo_wr = 1'b0; wr_data = 32'd0;
    tick; tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 ||
        mul_a !== 32'd0 || mul_b !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h mul_a=%h mul_b=%h want all 0",
               busy, done, hi, lo, mul_a, mul_b);
    end
    clear_n = 1'b1;
    do_mul(32'd5, 32'd12, 1'b0, 1'b0, "first_5x12");
    checks++;
    if (hi !== 32'h0 || lo !== 32'h3C) begin
      failures++;
      $display("FAIL const_5x12: hi=%h lo=%h want 00000000 0000003c", hi, lo);
    end
  endtask

  task automatic test_boundary;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "max_sq");
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      failures++;
      $display("FAIL const_max_sq: hi=%h lo=%h want fffffffe 00000001", hi, lo);
    end
    do_mul(32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_signed;
    logic [31:0] want_hi;
`ifdef MUL_SIGNED_EN
    want_hi = 32'hFFFF_FFFF;
`else
    want_hi = 32'h0000_000B;
`endif
    do_mul(32'hFFFF_FFFB, 32'd12, 1'b1, 1'b0, "neg5x12");
    checks++;
    if (hi !== want_hi || lo !== 32'hFFFF_FFC4) begin
      failures++;
      $display("FAIL const_neg5x12: hi=%h lo=%h want %h ffffffc4", hi, lo, want_hi);
    end
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, "minint_sq");
    do_mul(32'h8000_0000, 32'd1, 1'b1, 1'b0, "minint_x1");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, "neg_neg");
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom;
      if (i % 5 == 1) a = 32'h8000_0000;
      if (i % 7 == 2) b = 32'd0;
      do_mul(a, b, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back;
    int dones;
    logic [63:0] p;
    p = ref_prod(32'd3, 32'd4, 1'b0);
    op_a = 32'd3; op_b = 32'd4; is_signed = 1'b0; start = 1'b1;
    tick;
    op_a = 32'd99; op_b = 32'd77; hi_wr = 1'b1; wr_data = 32'h1234;
    dones = 0;
    for (int k = 1; k <= 8; k++) begin
      tick;
      if (k == 1) begin hi_wr = 1'b0; start = 1'b0; end
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || hi !== p[63:32] || lo !== p[31:0]) begin
      failures++;
      $display("FAIL busy_ignore: dones=%0d hi=%h lo=%h want dones=1 hi=%h lo=%h",
               dones, hi, lo, p[63:32], p[31:0]);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    op_a = 32'h1000; op_b = 32'h1000; is_signed = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b want 0 0 0 0", busy, hi, lo, done);
    end
    tick;
    clear_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL reset_abandon: activity=%0d hi=%h lo=%h want 0 0 0", dones, hi, lo);
    end
    do_mul(32'd7, 32'd6, 1'b0, 1'b0, "after_reset_7x6");
    checks++;
    if (lo !== 32'h2A) begin
      failures++;
      $display("FAIL const_7x6: lo=%h want 0000002a", lo);
    end
  endtask

  task automatic test_direct_write;
    logic [31:0] old_hi;
    logic [63:0] p;
    old_hi = hi;
    lo_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
    tick;
    lo_wr = 1'b0;
    checks++;
    if (lo !== 32'hDEAD_BEEF || hi !== old_hi) begin
      failures++;
      $display("FAIL lo_wr: hi=%h lo=%h want %h deadbeef", hi, lo, old_hi);
    end
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'hCAFE_F00D;
    tick;
    hi_wr = 1'b0; lo_wr = 1'b0;
    checks++;
    if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL both_wr: hi=%h lo=%h want cafef00d cafef00d", hi, lo);
    end
    hi_wr = 1'b1; wr_data = 32'h5555_AAAA;
    tick;
    hi_wr = 1'b0;
    checks++;
    if (hi !== 32'h5555_AAAA || lo !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL hi_wr: hi=%h lo=%h want 5555aaaa cafef00d", hi, lo);
    end
    p = ref_prod(32'h0002_0000, 32'h0003_0000, 1'b0);
    do_mul(32'h0002_0000, 32'h0003_0000, 1'b0, 1'b1, "start_plus_hiwr");
    checks++;
    if (hi !== p[63:32] || hi === 32'h0BAD_0BAD) begin
      failures++;
      $display("FAIL start_wins: hi=%h want %h", hi, p[63:32]);
    end
  endtask

  initial begin
    test_reset;
    test_boundary;
    test_signed;
    test_random;
    test_back_to_back;
    test_reset_mid;
    test_direct_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
